// File: rtl/hspi_txbuf_pkg.sv
// Shared types and constants for the HSPI TX ping-pong frame buffer.
package hspi_txbuf_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ACT  = 2'd1,
    RD_GAP  = 2'd2
  } rd_state_t;

  localparam logic [7:0] HDR_MAGIC   = 8'hA5;
  localparam int         HDR_MAGIC_W = 8;
  localparam int         HDR_RSVD_W  = 8;
  localparam int         HDR_CNT_W   = 16;
  localparam int         HDR_W       = HDR_MAGIC_W + HDR_RSVD_W + HDR_CNT_W;

  function automatic logic [HDR_W-1:0] hdr_word(input logic [HDR_CNT_W-1:0] cnt);
    return {HDR_MAGIC, {HDR_RSVD_W{1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/hspi_tx_pingpong_buf_if.sv
// Stream-in / engine-facing bundle of the HSPI TX ping-pong buffer.
interface hspi_tx_pingpong_buf_if #(
  parameter int DEPTH = 512,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          ram_csn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic          tx_act;
  logic          tx_done;
  logic [15:0]   frame_cnt;

  modport master (
    output s_valid, s_data, ram_csn, ram_addr, tx_done,
    input  s_ready, ram_rdata, tx_act, frame_cnt
  );

  modport slave (
    input  s_valid, s_data, ram_csn, ram_addr, tx_done,
    output s_ready, ram_rdata, tx_act, frame_cnt
  );
endinterface

// File: rtl/hspi_txbuf_dpram.sv
// Simple dual-port RAM, 2*DEPTH x DW, one write port and one registered
// read port with read enable; shaped for Gowin BSRAM inference.
module hspi_txbuf_dpram #(
  parameter int DEPTH = 512,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW:0]   i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:2*DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/hspi_tx_pingpong_buf.sv
// Ping-pong frame buffer feeding the HSPI TX engine RAM read port.
// Optional header word at bank address 0 when HSPI_TXBUF_HDR_EN is defined.
module hspi_tx_pingpong_buf
  import hspi_txbuf_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int DW    = 32
) (
  input  logic clk,
  input  logic rstn,
  hspi_tx_pingpong_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = RD_IDLE;
  localparam logic [1:0] S_ACT  = RD_ACT;
  localparam logic [1:0] S_GAP  = RD_GAP;

`ifdef HSPI_TXBUF_HDR_EN
  localparam logic [AW-1:0] PTR_START = AW'(1);
`else
  localparam logic [AW-1:0] PTR_START = '0;
`endif

  logic          r_wr_bank;
  logic [AW-1:0] r_wr_ptr;
  logic [1:0]    r_full;
  logic [1:0]    w_full_nxt;
  logic          r_rd_bank;
  logic [1:0]    r_state;
  logic [15:0]   r_frame_cnt;
  logic          w_beat;
  logic          w_last;
  logic          w_release;
  logic          w_re;
  logic [DW-1:0] w_ram_rdata;

  assign bus.s_ready   = ~r_full[r_wr_bank];
  assign bus.tx_act    = (r_state == S_ACT);
  assign bus.frame_cnt = r_frame_cnt;

  assign w_beat    = bus.s_valid & ~r_full[r_wr_bank];
  assign w_last    = w_beat && (r_wr_ptr == AW'(DEPTH-1));
  assign w_release = (r_state == S_ACT) && bus.tx_done;
  assign w_re      = ~bus.ram_csn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= PTR_START;
    end else if (w_beat) begin
      if (w_last) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_ptr  <= PTR_START;
      end else begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
    end
  end

  // Completion and release may hit different banks in the same cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_last)    w_full_nxt[r_wr_bank] = 1'b1;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_full <= 2'b00;
    else       r_full <= w_full_nxt;
  end

  // RD_GAP forces one low cycle so the engine sees a fresh tx_act edge per frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_rd_bank   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (r_full[r_rd_bank]) r_state <= S_ACT;
        S_ACT: begin
          if (bus.tx_done) begin
            r_state     <= S_GAP;
            r_rd_bank   <= ~r_rd_bank;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  hspi_txbuf_dpram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_beat),
    .i_waddr ({r_wr_bank, r_wr_ptr}),
    .i_wdata (bus.s_data),
    .i_re    (w_re),
    .i_raddr ({r_rd_bank, bus.ram_addr}),
    .o_rdata (w_ram_rdata)
  );

`ifdef HSPI_TXBUF_HDR_EN
  logic          r_hdr_sel;
  logic [DW-1:0] r_hdr_word;

  // Header is captured alongside the RAM read so both paths share the 1-cycle latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hdr_sel  <= 1'b0;
      r_hdr_word <= '0;
    end else if (w_re) begin
      r_hdr_sel  <= (bus.ram_addr == '0);
      r_hdr_word <= DW'(hdr_word(r_frame_cnt));
    end
  end

  assign bus.ram_rdata = r_hdr_sel ? r_hdr_word : w_ram_rdata;
`else
  assign bus.ram_rdata = w_ram_rdata;
`endif

  wr_wrap_chk : assert property (@(posedge clk) disable iff (!rstn)
    w_release |-> !(w_last && (r_wr_bank == r_rd_bank) && r_full[r_wr_bank]));

endmodule

// File: tb/tb_hspi_tx_pingpong_buf.sv
// Scoreboard bench for hspi_tx_pingpong_buf: frame-level reference model,
// randomized streaming with backpressure, reset and timing checks.
module tb_hspi_tx_pingpong_buf;
  localparam int DEPTH = 512;
  localparam int DW    = 32;
  localparam int AW    = $clog2(DEPTH);
`ifdef HSPI_TXBUF_HDR_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int P = DEPTH - OFF;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  hspi_tx_pingpong_buf_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
  hspi_tx_pingpong_buf #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: completed-but-unreleased frames (head = frame being read),
  // the partial frame being assembled, and expected read results.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] pq[$];
  logic [DW-1:0] exp_q[$];
  int            m_released = 0;
  logic [DW-1:0] nd;
  bit            b;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int full_cnt();
    return mq.size() / P;
  endfunction

  function automatic logic [DW-1:0] model_read(input int a);
    if (OFF == 1 && a == 0) return {8'hA5, 8'h00, 16'(m_released)};
    return mq[a - OFF];
  endfunction

  task automatic model_reset();
    mq.delete();
    pq.delete();
    exp_q.delete();
    m_released = 0;
  endtask

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit rd, input int a,
                     input bit done, output bit beat);
    bit mr;
    @(negedge clk);
    mr = (full_cnt() < 2);
    chk("s_ready", bus.s_ready, mr);
    bus.s_valid  = v;
    bus.s_data   = d;
    bus.ram_csn  = !rd;
    bus.ram_addr = AW'(a);
    bus.tx_done  = done;
    if (rd) exp_q.push_back(model_read(a));
    beat = v && mr;
    if (done && full_cnt() > 0) begin
      repeat (P) void'(mq.pop_front());
      m_released++;
    end
    if (beat) begin
      pq.push_back(d);
      if (pq.size() == P) begin
        foreach (pq[i]) mq.push_back(pq[i]);
        pq.delete();
      end
    end
  endtask

  task automatic idle();
    bit bb;
    cyc(1'b0, '0, 1'b0, 0, 1'b0, bb);
  endtask

  task automatic rd(input int a);
    bit bb;
    cyc(1'b0, '0, 1'b1, a, 1'b0, bb);
  endtask

  task automatic pulse_done();
    bit bb;
    cyc(1'b0, '0, 1'b0, 0, 1'b1, bb);
  endtask

  task automatic stream(input int n);
    int got = 0;
    int guard = 0;
    bit bb;
    while (got < n && guard < 4*n + 20) begin
      cyc(1'b1, nd, 1'b0, 0, 1'b0, bb);
      if (bb) begin
        nd++;
        got++;
      end
      guard++;
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", got, n);
    end
  endtask

  // Read-data monitor: one expectation popped per sampled read strobe.
  logic rd_fire;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) rd_fire <= 1'b0;
    else       rd_fire <= !bus.ram_csn;
  end

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read at %0t", bus.ram_rdata, $time);
      end else begin
        chk("ram_rdata", bus.ram_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    int rstate, cyc_n, ra, wait_n, start_rel;
    bit v, r, dn;
    int a;

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.ram_csn  = 1'b1;
    bus.ram_addr = '0;
    bus.tx_done  = 1'b0;
    rstn         = 1'b0;
    nd           = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_act", bus.tx_act, 1'b0);
    chk("rst_s_ready", bus.s_ready, 1'b1);
    chk("rst_ram_rdata", bus.ram_rdata, '0);
    chk("rst_frame_cnt", bus.frame_cnt, 16'd0);
    @(negedge clk);
    rstn = 1'b1;

    // First frame: tx_act rises two cycles after the final beat.
    stream(P);
    idle();
    chk("tx_act_edge1", bus.tx_act, 1'b0);
    idle();
    chk("tx_act_edge2", bus.tx_act, 1'b1);
    rd(5);
    rd(0);
    idle();

    // Fill second bank, then a blocked beat.
    stream(P);
    idle();
    chk("s_ready_both_full", bus.s_ready, 1'b0);
    cyc(1'b1, nd, 1'b0, 0, 1'b0, b);
    if (b) nd++;
    pulse_done();
    idle();
    chk("s_ready_after_rel", bus.s_ready, 1'b1);
    chk("tx_act_gap", bus.tx_act, 1'b0);
    idle();
    chk("tx_act_idle", bus.tx_act, 1'b0);
    idle();
    chk("tx_act_second", bus.tx_act, 1'b1);
    chk("frame_cnt_1", bus.frame_cnt, 16'd1);
    rd(0);
    rd(1);
    idle();

    // Release the second frame, then a tx_done with nothing pending.
    pulse_done();
    repeat (3) idle();
    chk("tx_act_empty", bus.tx_act, 1'b0);
    pulse_done();
    idle();
    idle();
    chk("frame_cnt_ignored", bus.frame_cnt, 16'd2);
    chk("tx_act_ignored", bus.tx_act, 1'b0);

    // Mid-run async reset with a frame pending and a partial frame in progress.
    stream(P + 100);
    idle();
    idle();
    chk("tx_act_pre_rst", bus.tx_act, 1'b1);
    rd(7);
    idle();
    idle();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_tx_act", bus.tx_act, 1'b0);
    chk("mid_rst_s_ready", bus.s_ready, 1'b1);
    chk("mid_rst_ram_rdata", bus.ram_rdata, '0);
    chk("mid_rst_frame_cnt", bus.frame_cnt, 16'd0);
    model_reset();
    @(negedge clk);
    #2 rstn = 1'b1;

    nd = 32'h1000_0000;
    stream(P);
    idle();
    idle();
    chk("tx_act_post_rst", bus.tx_act, 1'b1);
    rd(OFF);
    rd(0);
    idle();

    // Randomized streaming with reader releasing a frame every ~700 cycles.
    rstate    = 0;
    cyc_n     = 0;
    ra        = 0;
    wait_n    = 0;
    start_rel = m_released;
    while ((m_released - start_rel) < 4 && cyc_n < 8000) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = 1'b0;
      a  = 0;
      dn = 1'b0;
      case (rstate)
        0: if (cyc_n % 700 == 699) begin rstate = 1; wait_n = 0; end
        1: begin
          if (bus.tx_act) begin
            rstate = 2;
            ra = 0;
          end else begin
            wait_n++;
            if (wait_n > 1500) begin
              checks++;
              errors++;
              $display("FAIL tx_act_timeout: got tx_act=0 expected 1 within 1500 cycles");
              rstate = 0;
            end
          end
        end
        2: begin
          r = 1'b1;
          a = ra;
          ra++;
          if (ra == DEPTH) rstate = 3;
        end
        default: begin
          dn = 1'b1;
          rstate = 0;
        end
      endcase
      cyc(v, nd, r, a, dn, b);
      if (b) nd++;
      cyc_n++;
    end
    idle();
    idle();
    chk("rand_frames_released", (m_released - start_rel) >= 4, 1'b1);
    chk("frame_cnt_final", bus.frame_cnt, 16'(m_released));
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
